apb_share_arbiter: RTL and testbench
====================================

Name: apb_share_arbiter

Overview:
- Shares one APB completer port between NM APB requesters, e.g. several axi2apb bridges feeding one peripheral bus.
- Each requester's access phase is captured and replayed downstream as a fresh, protocol-correct SETUP/ACCESS pair.
- Arbitration is round-robin with a bounded ownership lock, so multi-transfer sequences (split 64-bit halves) stay atomic.
- An access-phase timeout returns SLVERR to the requester when the completer never answers.

Parameters:
NM, 4, number of requesters (2..8)
AWID, 32, address width
DWID, 32, APB data width; strobe width is DWID/8
MAXLOCK, 2, max consecutive transfers one owner may hold while keeping psel high
TMO, 255, access-phase cycles before timeout (1..65535)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
m_psel  in  NM  requester psel
m_penable  in  NM  requester penable
m_pwrite  in  NM  requester pwrite
m_paddr  in  NM*AWID  packed addresses, requester i at [i*AWID +: AWID]
m_pwdata  in  NM*DWID  packed write data
m_pstrb  in  NM*DWID/8  packed strobes
m_pready  out  NM  per-requester pready
m_prdata  out  DWID  read data, broadcast to all requesters
m_presp  out  NM*2  per-requester response
psel  out  1  completer select
penable  out  1  completer enable
pwrite  out  1  muxed from owner
paddr  out  AWID  muxed from owner
pwdata  out  DWID  muxed from owner
pstrb  out  DWID/8  muxed from owner; forced 0 when pwrite=0
pready  in  1  completer ready
prdata  in  DWID  completer read data
presp  in  2  completer response
grant  out  NM  one-hot owner, valid while state != IDLE or lock is held
timeout  out  1  one-cycle pulse on timeout
tmo_count  out  16  saturating timeout counter

Behaviour:
- Clock/reset: the one clock is clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, owner=0, lock=0, lockcnt=0, tmocnt=0, tmo_count=0.
  - All outputs 0 after reset: psel, penable, m_pready, m_presp, grant, timeout.
- Request definition: req[i] = m_psel[i] & m_penable[i], i.e. the requester is in its access phase.
  - A requester waiting for grant simply sees m_pready[i]=0 and holds its signals, as APB requires.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If lock=1 and m_psel[owner]=0: clear lock and lockcnt, then arbitrate this same cycle.
  - If lock=1 and m_psel[owner]=1: wait. Go to SETUP only when req[owner]; no other requester is granted.
  - If lock=0 and any req: choose the first requester with req set, searching owner+1, owner+2, ... mod NM. Load it into owner and go to SETUP.
  - After a lock release with lockcnt=MAXLOCK, the releasing owner has lowest priority.
- SETUP: psel=1, penable=0, always exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1; tmocnt increments each cycle.
  - On pready=1: m_pready[owner]=1 and m_presp[owner]=presp in this same cycle, combinationally; then IDLE.
  - On tmocnt==TMO-1 with pready=0: m_pready[owner]=1, m_presp[owner]=2'b10, timeout=1, tmo_count+=1 (saturate at 16'hFFFF), then IDLE.
  - Downstream psel drops next cycle, aborting the completer access.
  - Simultaneous pready and timeout: pready wins, no timeout.
- Lock update on completion: lockcnt+=1.
  - lock is set if lockcnt+1 < MAXLOCK; otherwise lock is cleared and lockcnt reset to 0.
  - A requester with psel still high after MAXLOCK transfers therefore re-enters round-robin.
- Latency: a request first seen at cycle T gives SETUP at T+1 and ACCESS at T+2. With a zero-wait completer, m_pready pulses at T+2.
- Outputs to non-owners: m_pready=0 and m_presp=0 at all times. m_prdata=prdata unconditionally.
- pwrite, paddr, pwdata, pstrb are muxed from owner and must be stable through SETUP and ACCESS. owner changes only in IDLE.
- Reset mid-transfer: state returns to IDLE at the next edge, psel/penable fall, and the interrupted requester receives no pready.
- A requester dropping psel while queued or in ACCESS is a protocol violation: the transfer still completes downstream and its pready is discarded.

Test Plan:
1. Single requester 1, write addr 0x40, data 0xA5A5A5A5, zero-wait completer -> psel rises at T+1, penable at T+2, m_pready[1] at T+2, downstream paddr=0x40, pwdata=0xA5A5A5A5.
2. All 4 requesting reads continuously, one transfer each, after reset -> grant order 1,2,3,0 (owner reset 0, search starts at 1), no cycle with two grants.
3. Requester 0 keeps psel high for 4 back-to-back transfers, requester 2 also requesting, MAXLOCK=2 -> order 0,0,2,0,0; requester 2 never waits more than 2 transfers.
4. Completer holds pready=0, TMO=255 -> at ACCESS cycle 255 m_presp[owner]=2'b10, timeout pulses once, tmo_count=1, psel low next cycle.
5. pready=1 on the same cycle tmocnt==TMO-1 -> m_presp=presp (OKAY 2'b00), timeout=0, tmo_count unchanged.
6. rst asserted during ACCESS -> next cycle psel=0, penable=0, grant=0, no m_pready; a subsequent request arbitrates normally with owner=0 priority start at 1.

Source files
------------

// File: rtl/apb_share_arbiter.sv
// Shares one APB completer between NM requesters: round-robin arbitration with a
// bounded ownership lock, SETUP/ACCESS replay downstream and an access-phase timeout.
module apb_share_arbiter #(
   parameter int NM      = 4,
   parameter int AWID    = 32,
   parameter int DWID    = 32,
   parameter int MAXLOCK = 2,
   parameter int TMO     = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NM-1:0]          m_psel,
   input  logic [NM-1:0]          m_penable,
   input  logic [NM-1:0]          m_pwrite,
   input  logic [NM*AWID-1:0]     m_paddr,
   input  logic [NM*DWID-1:0]     m_pwdata,
   input  logic [NM*DWID/8-1:0]   m_pstrb,
   output logic [NM-1:0]          m_pready,
   output logic [DWID-1:0]        m_prdata,
   output logic [NM*2-1:0]        m_presp,
   output logic                   psel,
   output logic                   penable,
   output logic                   pwrite,
   output logic [AWID-1:0]        paddr,
   output logic [DWID-1:0]        pwdata,
   output logic [DWID/8-1:0]      pstrb,
   input  logic                   pready,
   input  logic [DWID-1:0]        prdata,
   input  logic [1:0]             presp,
   output logic [NM-1:0]          grant,
   output logic                   timeout,
   output logic [15:0]            tmo_count
);

   localparam int OW = (NM > 1) ? $clog2(NM) : 1;
   localparam int SW = DWID / 8;
   localparam int LW = (MAXLOCK > 1) ? $clog2(MAXLOCK + 1) : 1;
   localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic          lock_q, lock_d;
   logic [LW-1:0] lockcnt_q, lockcnt_d;
   logic [15:0]   tmocnt_q, tmocnt_d;
   logic [15:0]   tmo_count_q, tmo_count_d;

   logic [NM-1:0] req_s;
   logic [OW-1:0] pick_s;
   logic          found_s;
   logic          done_s;
   logic          tmo_s;
   logic          cpl_s;

   function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
      return OW'((int'(base) + k) % NM);
   endfunction

   assign req_s  = m_psel & m_penable;
   // pready wins over a timeout landing on the same cycle
   assign done_s = (state_q == ACCESS) && pready;
   assign tmo_s  = (state_q == ACCESS) && !pready && (tmocnt_q == TMO_LAST);
   assign cpl_s  = done_s | tmo_s;

   // Descending scan so the requester nearest after the owner is the last one written
   always_comb begin
      pick_s  = '0;
      found_s = 1'b0;
      for (int k = NM; k >= 1; k--) begin
         pick_s  = req_s[rr_idx(owner_q, k)] ? rr_idx(owner_q, k) : pick_s;
         found_s = found_s | req_s[rr_idx(owner_q, k)];
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lock_d      = lock_q;
      lockcnt_d   = lockcnt_q;
      tmocnt_d    = tmocnt_q;
      tmo_count_d = tmo_count_q;
      case (state_q)
         IDLE: begin
            tmocnt_d = '0;
            if (lock_q && m_psel[owner_q]) begin
               if (req_s[owner_q]) begin
                  state_d = SETUP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               // a held lock whose owner has let go is dropped and arbitration runs now
               lock_d    = 1'b0;
               lockcnt_d = '0;
               if (found_s) begin
                  owner_d = pick_s;
                  state_d = SETUP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         SETUP: begin
            tmocnt_d = '0;
            state_d  = ACCESS;
         end
         ACCESS: begin
            if (cpl_s) begin
               state_d  = IDLE;
               tmocnt_d = '0;
               if (int'(lockcnt_q) + 1 < MAXLOCK) begin
                  lock_d    = 1'b1;
                  lockcnt_d = lockcnt_q + LW'(1);
               end else begin
                  lock_d    = 1'b0;
                  lockcnt_d = '0;
               end
            end else begin
               state_d  = ACCESS;
               tmocnt_d = tmocnt_q + 16'd1;
            end
            if (tmo_s && (tmo_count_q != 16'hFFFF)) begin
               tmo_count_d = tmo_count_q + 16'd1;
            end else begin
               tmo_count_d = tmo_count_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         lock_q      <= 1'b0;
         lockcnt_q   <= '0;
         tmocnt_q    <= '0;
         tmo_count_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lock_q      <= lock_d;
         lockcnt_q   <= lockcnt_d;
         tmocnt_q    <= tmocnt_d;
         tmo_count_q <= tmo_count_d;
      end
   end

   always_comb begin
      m_pready = '0;
      m_presp  = '0;
      grant    = '0;
      m_pready[owner_q]        = cpl_s;
      m_presp[2*owner_q +: 2]  = done_s ? presp : (tmo_s ? 2'b10 : 2'b00);
      grant[owner_q]           = (state_q != IDLE) || lock_q;
   end

   assign psel      = (state_q != IDLE);
   assign penable   = (state_q == ACCESS);
   assign pwrite    = m_pwrite[owner_q];
   assign paddr     = m_paddr[owner_q*AWID +: AWID];
   assign pwdata    = m_pwdata[owner_q*DWID +: DWID];
   assign pstrb     = pwrite ? m_pstrb[owner_q*SW +: SW] : '0;
   assign m_prdata  = prdata;
   assign timeout   = tmo_s;
   assign tmo_count = tmo_count_q;

endmodule

// File: tb/tb_apb_share_arbiter.sv
// Randomized bench for apb_share_arbiter: APB requester drivers, a configurable
// completer and a transaction-level model predicting every output each cycle.
module tb_apb_share_arbiter;

   localparam int NM      = 4;
   localparam int AWID    = 32;
   localparam int DWID    = 32;
   localparam int SW      = DWID / 8;
   localparam int MAXLOCK = 2;
   localparam int TMO     = 255;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NM-1:0]        m_psel = '0;
   logic [NM-1:0]        m_penable = '0;
   logic [NM-1:0]        m_pwrite = '0;
   logic [NM*AWID-1:0]   m_paddr = '0;
   logic [NM*DWID-1:0]   m_pwdata = '0;
   logic [NM*SW-1:0]     m_pstrb = '0;
   logic [NM-1:0]        m_pready;
   logic [DWID-1:0]      m_prdata;
   logic [NM*2-1:0]      m_presp;
   logic                 psel, penable, pwrite;
   logic [AWID-1:0]      paddr;
   logic [DWID-1:0]      pwdata;
   logic [SW-1:0]        pstrb;
   logic                 pready = 1'b0;
   logic [DWID-1:0]      prdata = '0;
   logic [1:0]           presp = 2'b00;
   logic [NM-1:0]        grant;
   logic                 timeout;
   logic [15:0]          tmo_count;

   always #5 clk = ~clk;

   apb_share_arbiter #(
      .NM(NM), .AWID(AWID), .DWID(DWID), .MAXLOCK(MAXLOCK), .TMO(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
      .m_pready(m_pready), .m_prdata(m_prdata), .m_presp(m_presp),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
      .presp(presp), .grant(grant), .timeout(timeout), .tmo_count(tmo_count)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // model: current transfer (owner, decision cycle), hold run length, timeout total
   bit md_busy, md_held;
   int md_own, md_gcyc, md_consec, md_tmo;
   int last_done = -1;

   int rq_phase[NM];
   int rq_left[NM];
   bit rq_b2b[NM];
   int rq_pct = 100;
   int cmode = 0;
   bit fix_en = 1'b0;

   int obs[$];
   int n_tmo_obs = 0;
   bit t1_on = 1'b0;
   int t1_req = -1;
   int t1_rdy = -1;
   logic [31:0] t1_addr, t1_data;
   logic t1_wr;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      md_busy = 1'b0; md_held = 1'b0;
      md_own = 0; md_gcyc = 0; md_consec = 0; md_tmo = 0;
      last_done = -1;
   endtask

   task automatic rq_reset();
      m_psel = '0; m_penable = '0;
      for (int i = 0; i < NM; i++) begin
         rq_phase[i] = 0;
         rq_left[i]  = 0;
         rq_b2b[i]   = 1'b0;
      end
   endtask

   task automatic new_xfer(input int i);
      rq_left[i]--;
      m_psel[i]    = 1'b1;
      m_penable[i] = 1'b0;
      rq_phase[i]  = 1;
      if (fix_en) begin
         m_paddr[i*AWID +: AWID]  = 32'h0000_0040;
         m_pwdata[i*DWID +: DWID] = 32'hA5A5_A5A5;
         m_pwrite[i]              = 1'b1;
         m_pstrb[i*SW +: SW]      = 4'hF;
      end else begin
         m_paddr[i*AWID +: AWID]  = $urandom;
         m_pwdata[i*DWID +: DWID] = $urandom;
         m_pwrite[i]              = 1'($urandom_range(1));
         m_pstrb[i*SW +: SW]      = 4'($urandom_range(15));
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NM; i++) begin
         if (rq_phase[i] == 2 && last_done == i) begin
            if (rq_left[i] > 0 && rq_b2b[i]) new_xfer(i);
            else begin
               m_psel[i] = 1'b0; m_penable[i] = 1'b0; rq_phase[i] = 0;
            end
         end else if (rq_phase[i] == 1) begin
            m_penable[i] = 1'b1; rq_phase[i] = 2;
         end else if (rq_phase[i] == 0 && rq_left[i] > 0 && $urandom_range(99) < rq_pct) begin
            new_xfer(i);
         end
      end
      prdata = $urandom;
      presp  = 2'($urandom_range(3));
      case (cmode)
         0: pready = ($urandom_range(99) < 60);
         1: pready = 1'b0;
         2: begin
            pready = md_busy && (cyc - md_gcyc - 2 == TMO - 1);
            presp  = 2'b00;
         end
         default: pready = 1'b1;
      endcase
   endtask

   task automatic cycle();
      logic [NM-1:0] req, e_rdy, e_grant;
      logic [2*NM-1:0] e_resp;
      logic e_psel, e_pen, e_tmo, e_wr, rst_s;
      int pick, done_now, age;
      drive_inputs();
      #4;
      rst_s = rst;
      req = m_psel & m_penable;
      e_rdy = '0; e_grant = '0; e_resp = '0;
      e_psel = 1'b0; e_pen = 1'b0; e_tmo = 1'b0;
      pick = -1; done_now = -1;
      if (!md_busy) begin
         if (md_held) e_grant[md_own] = 1'b1;
         if (md_held && !m_psel[md_own]) begin
            md_held = 1'b0; md_consec = 0;
         end
         if (md_held) begin
            if (req[md_own]) pick = md_own;
         end else begin
            for (int k = NM; k >= 1; k--)
               if (req[(md_own + k) % NM]) pick = (md_own + k) % NM;
         end
      end else begin
         age = cyc - md_gcyc;
         e_psel = 1'b1;
         e_pen = (age >= 2);
         e_grant[md_own] = 1'b1;
         if (age >= 2) begin
            if (pready) begin
               done_now = md_own; e_resp[2*md_own +: 2] = presp;
            end else if (age - 2 == TMO - 1) begin
               done_now = md_own; e_resp[2*md_own +: 2] = 2'b10; e_tmo = 1'b1;
            end
            if (done_now >= 0) e_rdy[md_own] = 1'b1;
         end
      end
      check_val("psel", psel, e_psel);
      check_val("penable", penable, e_pen);
      check_val("grant", grant, e_grant);
      check_val("m_pready", m_pready, e_rdy);
      check_val("m_presp", m_presp, e_resp);
      check_val("timeout", timeout, e_tmo);
      check_val("tmo_count", tmo_count, 16'(md_tmo));
      check_val("m_prdata", m_prdata, prdata);
      if (e_psel) begin
         e_wr = m_pwrite[md_own];
         check_val("pwrite", pwrite, e_wr);
         check_val("paddr", paddr, m_paddr[md_own*AWID +: AWID]);
         check_val("pwdata", pwdata, m_pwdata[md_own*DWID +: DWID]);
         check_val("pstrb", pstrb, e_wr ? m_pstrb[md_own*SW +: SW] : 4'h0);
      end
      if (psel && !penable)
         for (int i = 0; i < NM; i++) if (grant[i]) obs.push_back(i);
      if (timeout === 1'b1) n_tmo_obs++;
      if (t1_on && req[1] && t1_req < 0) t1_req = cyc;
      if (t1_on && m_pready[1] && t1_rdy < 0) begin
         t1_rdy = cyc; t1_addr = paddr; t1_data = pwdata; t1_wr = pwrite;
      end
      @(posedge clk);
      #1;
      if (rst_s) begin
         model_reset();
      end else if (!md_busy) begin
         if (pick >= 0) begin
            md_busy = 1'b1; md_own = pick; md_gcyc = cyc;
         end
      end else if (done_now >= 0) begin
         md_busy = 1'b0;
         md_consec++;
         if (md_consec < MAXLOCK) md_held = 1'b1;
         else begin
            md_held = 1'b0; md_consec = 0;
         end
         if (e_tmo && md_tmo < 65535) md_tmo++;
      end
      last_done = rst_s ? -1 : done_now;
      if (rst_s) rq_reset();
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rq_reset();
      pready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      cyc++;
   endtask

   initial begin
      int t2_exp[4];
      int t3_exp[5];
      t2_exp = '{1, 2, 3, 0};
      t3_exp = '{0, 0, 2, 0, 0};

      do_reset();
      check_val("rst_psel", psel, 1'b0);
      check_val("rst_penable", penable, 1'b0);
      check_val("rst_m_pready", m_pready, 4'h0);
      check_val("rst_m_presp", m_presp, 8'h00);
      check_val("rst_grant", grant, 4'h0);
      check_val("rst_timeout", timeout, 1'b0);
      check_val("rst_tmo_count", tmo_count, 16'h0000);

      // single write from requester 1 against a zero-wait completer
      fix_en = 1'b1; cmode = 3; rq_pct = 100; rq_left[1] = 1; t1_on = 1'b1;
      repeat (10) cycle();
      t1_on = 1'b0; fix_en = 1'b0;
      check_val("t1_latency", 64'(t1_rdy - t1_req), 64'd2);
      check_val("t1_paddr", t1_addr, 32'h0000_0040);
      check_val("t1_pwdata", t1_data, 32'hA5A5_A5A5);
      check_val("t1_pwrite", t1_wr, 1'b1);

      // all four requesters, one transfer each, from reset
      do_reset();
      obs.delete(); cmode = 0;
      for (int i = 0; i < NM; i++) rq_left[i] = 1;
      repeat (50) cycle();
      check_val("t2_count", obs.size(), 4);
      for (int k = 0; k < 4 && k < obs.size(); k++)
         check_val($sformatf("t2_order%0d", k), obs[k], t2_exp[k]);

      // requester 0 streams four transfers, requester 2 joins slightly later
      do_reset();
      obs.delete(); cmode = 0;
      rq_left[0] = 4; rq_b2b[0] = 1'b1;
      for (int k = 0; k < 80; k++) begin
         if (k == 2) rq_left[2] = 1;
         cycle();
      end
      check_val("t3_count", obs.size(), 5);
      for (int k = 0; k < 5 && k < obs.size(); k++)
         check_val($sformatf("t3_order%0d", k), obs[k], t3_exp[k]);

      // completer never answers
      do_reset();
      cmode = 1; n_tmo_obs = 0; rq_left[3] = 1;
      repeat (270) cycle();
      check_val("t4_tmo_count", tmo_count, 16'd1);
      check_val("t4_pulses", n_tmo_obs, 1);

      // pready lands exactly on the timeout cycle
      cmode = 2; n_tmo_obs = 0; rq_left[1] = 1;
      repeat (270) cycle();
      check_val("t5_tmo_count", tmo_count, 16'd1);
      check_val("t5_pulses", n_tmo_obs, 0);
      check_val("t5_done", rq_phase[1], 0);

      // reset in the middle of an access phase
      do_reset();
      cmode = 1; rq_left[3] = 1;
      for (int k = 0; k < 20 && !(md_busy && cyc - md_gcyc >= 2); k++) cycle();
      check_val("t6_in_access", md_busy && (cyc - md_gcyc >= 2), 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_val("t6_psel", psel, 1'b0);
      check_val("t6_grant", grant, 4'h0);
      obs.delete(); cmode = 0;
      rq_left[0] = 1; rq_left[2] = 1;
      repeat (40) cycle();
      check_val("t6_count", obs.size(), 2);
      if (obs.size() >= 2) begin
         check_val("t6_first", obs[0], 2);
         check_val("t6_second", obs[1], 0);
      end

      // long randomized mix
      cmode = 0; rq_pct = 30;
      for (int k = 0; k < 1500; k++) begin
         if (k % 300 == 0)
            for (int i = 0; i < NM; i++) begin
               rq_left[i] = rq_left[i] + $urandom_range(8, 3);
               rq_b2b[i]  = 1'($urandom_range(1));
            end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
